// File: rtl/stim_gen_pkg.sv
// Shared types and helpers for the stim_toggle_gen toggle-pattern generator.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package stim_gen_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   // Width of a channel-select field; stays at least one bit for a single channel.
   function automatic int ch_sel_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   // Half-period loaded at reset: channel k toggles every k+1 cycles.
   function automatic int default_hp(input int k);
      return k + 1;
   endfunction

endpackage

// File: rtl/stim_chan.sv
// One square-wave channel: half-period counter, compare, toggle flop.
// Latency: toggle registered on the edge where cnt reaches hp-1; load is one edge.
// Backpressure: none; free-running while i_run is high.
//
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   i_run        count/toggle enable for this edge (RUN and not stopping)
//   i_load       pattern start: load i_init, clear counter
//   i_clr        period rewrite: clear counter (toggle of this edge still happens)
//   i_init       level loaded on i_load
//   i_hp         current half-period; 0 freezes the channel
//   o_out        channel level
//   o_tog        this edge toggles the channel (combinational)
module stim_chan #(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_run,
   input  logic             i_load,
   input  logic             i_clr,
   input  logic             i_init,
   input  logic [CNT_W-1:0] i_hp,
   output logic             o_out,
   output logic             o_tog
);

   logic [CNT_W-1:0] r_cnt;
   logic             r_out;
   logic             w_frozen;

   assign w_frozen = (i_hp == '0);
   assign o_tog    = i_run && !w_frozen && (r_cnt == (i_hp - CNT_W'(1)));
   assign o_out    = r_out;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_out <= 1'b0;
         r_cnt <= '0;
      end else if (i_load) begin
         r_out <= i_init;
         r_cnt <= '0;
      end else begin
         if (o_tog) begin
            r_out <= ~r_out;
         end
         // A rewrite restarts the count even if it lands on a toggle edge.
         if (i_clr || o_tog || w_frozen) begin
            r_cnt <= '0;
         end else if (i_run) begin
            r_cnt <= r_cnt + CNT_W'(1);
         end
      end
   end

endmodule

// File: rtl/stim_toggle_gen.sv
// Multi-channel programmable square-wave generator with start/stop and wrap pulse.
// Latency: start -> out=init_val after one edge; channel k first toggles hp[k] edges later.
// Backpressure: none; outputs are free-running, no ready handshake.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   start, stop         pattern control (stop wins when both are high)
//   init_val            channel levels loaded on start
//   period_we/ch/val    half-period register write, any state; 0 freezes a channel
//   burst_len, done     RUN length and completion pulse (STIM_GEN_BURST_EN only)
//   out                 channel levels
//   busy                high while running
//   wrap                registered pulse: every live channel toggled on the same edge
//
// Optional feature macro: STIM_GEN_BURST_EN (burst-limited RUN with done pulse).
module stim_toggle_gen
   import stim_gen_pkg::*;
#(
   parameter  int NUM_CH   = 4,
   parameter  int CNT_W    = 8,
   localparam int CH_SEL_W = ch_sel_w(NUM_CH)
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                start,
   input  logic                stop,
   input  logic [NUM_CH-1:0]   init_val,
   input  logic                period_we,
   input  logic [CH_SEL_W-1:0] period_ch,
   input  logic [CNT_W-1:0]    period_val,
`ifdef STIM_GEN_BURST_EN
   input  logic [CNT_W-1:0]    burst_len,
   output logic                done,
`endif
   output logic [NUM_CH-1:0]   out,
   output logic                busy,
   output logic                wrap
);

   state_t            r_state;
   state_t            w_state_nxt;
   logic              w_load;
   logic              w_run;
   logic              w_burst_end;
   logic              r_wrap;
   logic [NUM_CH-1:0] w_tog;
   logic [NUM_CH-1:0] w_live;
   logic [NUM_CH-1:0] w_out;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // w_run qualifies counting on this edge: a stopping edge never toggles.
   always_comb begin
      w_state_nxt = r_state;
      w_load      = 1'b0;
      w_run       = 1'b0;
      case (r_state)
         IDLE: begin
            if (start && !stop) begin
               w_state_nxt = RUN;
               w_load      = 1'b1;
            end
         end
         RUN: begin
            if (stop) begin
               w_state_nxt = IDLE;
            end else begin
               w_run = 1'b1;
               if (w_burst_end) begin
                  w_state_nxt = IDLE;
               end
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   // Per-channel half-period register plus channel instance. Selects that do not
   // match any channel index fall through, so out-of-range writes are dropped.
   for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
      logic             w_we;
      logic [CNT_W-1:0] r_hp;

      assign w_we = period_we && (period_ch == CH_SEL_W'(k));

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            r_hp <= CNT_W'(default_hp(k));
         end else if (w_we) begin
            r_hp <= period_val;
         end
      end

      assign w_live[k] = (r_hp != '0);

      stim_chan #(
         .CNT_W (CNT_W)
      ) u_chan (
         .clk    (clk),
         .rst_n  (rst_n),
         .i_run  (w_run),
         .i_load (w_load),
         .i_clr  (w_we),
         .i_init (init_val[k]),
         .i_hp   (r_hp),
         .o_out  (w_out[k]),
         .o_tog  (w_tog[k])
      );
   end

   // Toggles only happen on live channels, so equality means all live ones fired.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wrap <= 1'b0;
      end else begin
         r_wrap <= w_run && (|w_tog) && (w_tog == w_live);
      end
   end

`ifdef STIM_GEN_BURST_EN
   logic [CNT_W-1:0] r_blen;
   logic [CNT_W-1:0] r_bcnt;
   logic             r_done;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_blen <= '0;
         r_bcnt <= '0;
         r_done <= 1'b0;
      end else begin
         // w_run is low on a stop edge, so stop at completion suppresses done.
         r_done <= w_run && w_burst_end;
         if (w_load) begin
            r_blen <= burst_len;
            r_bcnt <= '0;
         end else if (w_run) begin
            r_bcnt <= r_bcnt + CNT_W'(1);
         end
      end
   end

   // r_bcnt holds RUN edges already taken; this edge is the burst_len-th one.
   assign w_burst_end = (r_blen != '0) && (r_bcnt == (r_blen - CNT_W'(1)));
   assign done        = r_done;
`else
   assign w_burst_end = 1'b0;
`endif

   assign out  = w_out;
   assign busy = (r_state == RUN);
   assign wrap = r_wrap;

endmodule

// File: tb/tb_stim_toggle_gen.sv
// Testbench for stim_toggle_gen: time-schedule reference model feeding a scoreboard.
// Latency: expectations pushed per driven edge, popped one edge later.
// Backpressure: n/a.
module tb_stim_toggle_gen;
   import stim_gen_pkg::*;

   localparam int NUM_CH   = 4;
   localparam int CNT_W    = 8;
   localparam int CH_SEL_W = ch_sel_w(NUM_CH);

   logic                clk = 1'b0;
   logic                rst_n = 1'b1;
   logic                start = 1'b0;
   logic                stop = 1'b0;
   logic [NUM_CH-1:0]   init_val = '0;
   logic                period_we = 1'b0;
   logic [CH_SEL_W-1:0] period_ch = '0;
   logic [CNT_W-1:0]    period_val = '0;
   logic [NUM_CH-1:0]   out;
   logic                busy;
   logic                wrap;
   logic                done_obs;
`ifdef STIM_GEN_BURST_EN
   logic [CNT_W-1:0]    burst_len = '0;
   logic                done;
   assign done_obs = done;
`else
   assign done_obs = 1'b0;
`endif

   typedef struct packed {
      logic [NUM_CH-1:0] out;
      logic              busy;
      logic              wrap;
      logic              done;
   } exp_t;

   exp_t sb[$];
   exp_t e;
   int   n_cmp = 0;
   int   n_fail = 0;

   // Reference model: absolute edge number of each channel's next toggle.
   int                cyc = 0;
   bit                m_run;
   logic [NUM_CH-1:0] m_out;
   logic              m_wrap;
   logic              m_done;
   int                m_hp   [NUM_CH];
   int                m_next [NUM_CH];
   int                m_blen;
   int                m_bcnt;

   stim_toggle_gen #(
      .NUM_CH (NUM_CH),
      .CNT_W  (CNT_W)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .stop       (stop),
      .init_val   (init_val),
      .period_we  (period_we),
      .period_ch  (period_ch),
      .period_val (period_val),
`ifdef STIM_GEN_BURST_EN
      .burst_len  (burst_len),
      .done       (done),
`endif
      .out        (out),
      .busy       (busy),
      .wrap       (wrap)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: got time limit expired, want run complete");
      $fatal(1, "watchdog");
   end

   task automatic model_reset();
      m_run  = 1'b0;
      m_out  = '0;
      m_wrap = 1'b0;
      m_done = 1'b0;
      m_blen = 0;
      m_bcnt = 0;
      for (int k = 0; k < NUM_CH; k++) begin
         m_hp[k]   = k + 1;
         m_next[k] = 0;
      end
   endtask

   task automatic model_edge();
      logic [NUM_CH-1:0] tog;
      bit act;
      bit all_live;
      cyc++;
      act      = m_run && !stop;
      tog      = '0;
      all_live = 1'b1;
      for (int k = 0; k < NUM_CH; k++) begin
         if (act && m_hp[k] != 0) begin
            if (cyc == m_next[k]) tog[k] = 1'b1;
            else                  all_live = 1'b0;
         end
      end
      m_wrap = act && (tog != '0) && all_live;
      m_done = 1'b0;
      m_out  = m_out ^ tog;
      for (int k = 0; k < NUM_CH; k++) begin
         if (tog[k]) m_next[k] = m_next[k] + m_hp[k];
      end
      if (m_run && stop) begin
         m_run = 1'b0;
      end else if (act) begin
         m_bcnt++;
         if (m_blen != 0 && m_bcnt == m_blen) begin
            m_run  = 1'b0;
            m_done = 1'b1;
         end
      end else if (!m_run && start && !stop) begin
         m_run  = 1'b1;
         m_out  = init_val;
         m_bcnt = 0;
`ifdef STIM_GEN_BURST_EN
         m_blen = int'(burst_len);
`endif
         for (int k = 0; k < NUM_CH; k++) m_next[k] = cyc + m_hp[k];
      end
      if (period_we && int'(period_ch) < NUM_CH) begin
         m_hp[int'(period_ch)]   = int'(period_val);
         m_next[int'(period_ch)] = cyc + int'(period_val);
      end
   endtask

   // Push the expectation for the coming edge, take the edge, release pulses.
   task automatic tick();
      exp_t x;
      model_edge();
      x = '{out: m_out, busy: m_run, wrap: m_wrap, done: m_done};
      sb.push_back(x);
      @(posedge clk);
      #1;
      start     = 1'b0;
      stop      = 1'b0;
      period_we = 1'b0;
   endtask

   task automatic test_reset();
      model_reset();
      #2 rst_n = 1'b0;
      #10;
      n_cmp++;
      if ({out, busy, wrap, done_obs} !== 7'b0) begin
         n_fail++;
         $display("FAIL reset_state: got %b want %b", {out, busy, wrap, done_obs}, 7'b0);
      end
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         e = sb.pop_front();
         n_cmp++;
         if ({out, busy, wrap, done_obs} !== e) begin
            n_fail++;
            $display("FAIL reset_idle[%0d]: got %b want %b", i, {out, busy, wrap, done_obs}, e);
         end
      end
   endtask

   task automatic test_default();
      int first_wrap;
      first_wrap = -1;
      init_val = 4'b0111;
      start    = 1'b1;
      tick();
      e = sb.pop_front();
      n_cmp++;
      if ({out, busy, wrap, done_obs} !== e || out !== 4'b0111 || busy !== 1'b1) begin
         n_fail++;
         $display("FAIL default_start: got %b want %b", {out, busy, wrap, done_obs}, e);
      end
      for (int i = 1; i <= 14; i++) begin
         tick();
         e = sb.pop_front();
         n_cmp++;
         if ({out, busy, wrap, done_obs} !== e) begin
            n_fail++;
            $display("FAIL default[%0d]: got %b want %b", i, {out, busy, wrap, done_obs}, e);
         end
         if (wrap === 1'b1 && first_wrap < 0) first_wrap = i;
      end
      n_cmp++;
      if (first_wrap !== 12) begin
         n_fail++;
         $display("FAIL default_first_wrap: got edge %0d want edge 12", first_wrap);
      end
   endtask

   task automatic test_reprogram();
      logic prev;
      int   first_tog;
      first_tog  = -1;
      period_we  = 1'b1;
      period_ch  = 2'd2;
      period_val = 8'd5;
      tick();
      e = sb.pop_front();
      n_cmp++;
      if ({out, busy, wrap, done_obs} !== e) begin
         n_fail++;
         $display("FAIL reprog_write: got %b want %b", {out, busy, wrap, done_obs}, e);
      end
      prev = out[2];
      for (int i = 1; i <= 12; i++) begin
         tick();
         e = sb.pop_front();
         n_cmp++;
         if ({out, busy, wrap, done_obs} !== e) begin
            n_fail++;
            $display("FAIL reprog[%0d]: got %b want %b", i, {out, busy, wrap, done_obs}, e);
         end
         if (out[2] !== prev && first_tog < 0) first_tog = i;
      end
      n_cmp++;
      if (first_tog !== 5) begin
         n_fail++;
         $display("FAIL reprog_ch2_first: got edge %0d want edge 5", first_tog);
      end
      // ch0 toggles every edge, so this rewrite lands on a toggle.
      prev       = out[0];
      period_we  = 1'b1;
      period_ch  = 2'd0;
      period_val = 8'd3;
      tick();
      e = sb.pop_front();
      n_cmp++;
      if ({out, busy, wrap, done_obs} !== e || out[0] !== ~prev) begin
         n_fail++;
         $display("FAIL reprog_on_toggle: got %b want %b", {out, busy, wrap, done_obs}, e);
      end
      for (int i = 1; i <= 8; i++) begin
         tick();
         e = sb.pop_front();
         n_cmp++;
         if ({out, busy, wrap, done_obs} !== e) begin
            n_fail++;
            $display("FAIL reprog_ch0[%0d]: got %b want %b", i, {out, busy, wrap, done_obs}, e);
         end
      end
   endtask

   task automatic test_freeze();
      logic held;
      int   wraps;
      wraps      = 0;
      period_we  = 1'b1;
      period_ch  = 2'd1;
      period_val = 8'd0;
      tick();
      e = sb.pop_front();
      held = out[1];
      for (int i = 0; i < 62; i++) begin
         tick();
         e = sb.pop_front();
         n_cmp++;
         if ({out, busy, wrap, done_obs} !== e || out[1] !== held) begin
            n_fail++;
            $display("FAIL freeze[%0d]: got %b want %b", i, {out, busy, wrap, done_obs}, e);
         end
         if (wrap === 1'b1) wraps++;
      end
      n_cmp++;
      if (wraps < 1) begin
         n_fail++;
         $display("FAIL freeze_wrap_seen: got %0d wraps want at least 1", wraps);
      end
   endtask

   task automatic test_max_period();
      logic prev;
      int   first_tog;
      first_tog  = -1;
      period_we  = 1'b1;
      period_ch  = 2'd3;
      period_val = 8'd255;
      tick();
      e = sb.pop_front();
      prev = out[3];
      for (int i = 1; i <= 258; i++) begin
         tick();
         e = sb.pop_front();
         n_cmp++;
         if ({out, busy, wrap, done_obs} !== e) begin
            n_fail++;
            $display("FAIL maxhp[%0d]: got %b want %b", i, {out, busy, wrap, done_obs}, e);
         end
         if (out[3] !== prev && first_tog < 0) first_tog = i;
      end
      n_cmp++;
      if (first_tog !== 255) begin
         n_fail++;
         $display("FAIL maxhp_first: got edge %0d want edge 255", first_tog);
      end
   endtask

   task automatic test_collision();
      logic [NUM_CH-1:0] held;
      start = 1'b1;  // ignored in RUN
      tick();
      e = sb.pop_front();
      n_cmp++;
      if ({out, busy, wrap, done_obs} !== e) begin
         n_fail++;
         $display("FAIL start_in_run: got %b want %b", {out, busy, wrap, done_obs}, e);
      end
      held  = out;
      start = 1'b1;
      stop  = 1'b1;
      tick();
      e = sb.pop_front();
      n_cmp++;
      if ({out, busy, wrap, done_obs} !== e || busy !== 1'b0 || out !== held) begin
         n_fail++;
         $display("FAIL collide_run: got %b want %b", {out, busy, wrap, done_obs}, e);
      end
      for (int i = 0; i < 3; i++) begin
         tick();
         e = sb.pop_front();
         n_cmp++;
         if ({out, busy, wrap, done_obs} !== e) begin
            n_fail++;
            $display("FAIL idle_hold[%0d]: got %b want %b", i, {out, busy, wrap, done_obs}, e);
         end
      end
      start = 1'b1;
      stop  = 1'b1;
      tick();
      e = sb.pop_front();
      n_cmp++;
      if ({out, busy, wrap, done_obs} !== e || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL collide_idle: got %b want %b", {out, busy, wrap, done_obs}, e);
      end
   endtask

   task automatic test_async_reset();
      init_val = 4'b1010;
      start    = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         e = sb.pop_front();
         n_cmp++;
         if ({out, busy, wrap, done_obs} !== e) begin
            n_fail++;
            $display("FAIL pre_arst[%0d]: got %b want %b", i, {out, busy, wrap, done_obs}, e);
         end
      end
      #3 rst_n = 1'b0;
      #1;
      model_reset();
      n_cmp++;
      if ({out, busy, wrap, done_obs} !== 7'b0) begin
         n_fail++;
         $display("FAIL async_reset: got %b want %b", {out, busy, wrap, done_obs}, 7'b0);
      end
      #1 rst_n = 1'b1;
      for (int i = 0; i < 2; i++) begin
         tick();
         e = sb.pop_front();
         n_cmp++;
         if ({out, busy, wrap, done_obs} !== e) begin
            n_fail++;
            $display("FAIL post_arst[%0d]: got %b want %b", i, {out, busy, wrap, done_obs}, e);
         end
      end
   endtask

`ifdef STIM_GEN_BURST_EN
   task automatic test_burst();
      int busy_cnt;
      int done_at;
      busy_cnt = 0;
      done_at  = -1;
      stop     = 1'b1;
      tick();
      e = sb.pop_front();
      burst_len = 8'd10;
      init_val  = 4'b0000;
      start     = 1'b1;
      for (int i = 0; i <= 13; i++) begin
         tick();
         e = sb.pop_front();
         n_cmp++;
         if ({out, busy, wrap, done_obs} !== e) begin
            n_fail++;
            $display("FAIL burst[%0d]: got %b want %b", i, {out, busy, wrap, done_obs}, e);
         end
         if (busy === 1'b1) busy_cnt++;
         if (done === 1'b1 && done_at < 0) done_at = i;
      end
      n_cmp++;
      if (busy_cnt !== 10 || done_at !== 10) begin
         n_fail++;
         $display("FAIL burst_len: got busy %0d done@%0d want busy 10 done@10", busy_cnt, done_at);
      end
      burst_len = 8'd0;
   endtask
`endif

   initial begin
      test_reset();
      test_default();
      test_reprogram();
      test_freeze();
      test_max_period();
      test_collision();
      test_async_reset();
      test_default();
`ifdef STIM_GEN_BURST_EN
      test_burst();
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/stim_toggle_gen.md
# stim_toggle_gen

Parametrised multi-channel toggle-pattern generator. It is the synthesizable successor to bench-side `always`/`#delay` stimulus. It drives NUM_CH independent square-wave channels, and each channel toggles at its own programmable half-period. Outputs feed gate-level blocks under test on-chip or in simulation. Start/stop control, runtime period reprogramming, and a pattern-repeat pulse are included.

## Interface
- NUM_CH, 4: number of output channels (1..32)
- CNT_W, 8: width of half-period registers and counters
- clk  in  1  system clock, rising-edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  begin pattern (sampled in IDLE only)
- stop  in  1  end pattern, return to IDLE
- init_val  in  NUM_CH  channel levels loaded on start
- period_we  in  1  write strobe for a half-period register
- period_ch  in  $clog2(NUM_CH) (min 1)  channel select for write
- period_val  in  CNT_W  half-period in cycles; 0 = channel frozen
- burst_len  in  CNT_W  RUN length in cycles, 0 = unlimited (only with STIM_GEN_BURST_EN)
- out  out  NUM_CH  channel outputs
- busy  out  1  high in RUN
- wrap  out  1  one-cycle pulse: every non-frozen channel toggled this cycle
- done  out  1  one-cycle pulse on burst completion (only with STIM_GEN_BURST_EN)

## Operation
- States: IDLE, RUN. With STIM_GEN_BURST_EN, RUN also exits to IDLE on burst completion.
- Reset values: state IDLE, out = 0, busy = 0, wrap = 0, done = 0, all counters 0, hp[k] = k+1 (channel 0 toggles every cycle, channel 3 every 4).
- IDLE→RUN on start. out ← init_val, all cnt[k] ← 0, busy ← 1.
- RUN: each channel with hp[k] ≠ 0 increments cnt[k]. When cnt[k] == hp[k]−1, out[k] inverts and cnt[k] ← 0. Channels with hp[k] = 0 hold their level and keep cnt at 0.
- RUN→IDLE on stop. out holds its last value and busy ← 0.
- start and stop together: stop wins. In IDLE, nothing happens. In RUN, the block goes to IDLE.
- start while in RUN is ignored; it does not restart the pattern.
- Period write: hp[period_ch] ← period_val and cnt[period_ch] ← 0 in the same edge. This is legal in any state. A write to period_ch ≥ NUM_CH is ignored.
- A write coinciding with that channel's toggle: the toggle still occurs, then the new period applies from cnt = 0.
- wrap is asserted in RUN on a cycle where at least one channel toggles and every channel with hp ≠ 0 toggles. It is never asserted in IDLE.
- Counters compare at full CNT_W width. hp = 2^CNT_W−1 is the maximum half-period, and there is no overflow path.

## Timing
- start sampled at edge T0 → out = init_val and busy = 1 visible after T0.
- Channel k first toggles at edge T0 + hp[k], then every hp[k] edges after that.
- stop at edge Ts → no toggle at Ts, and busy = 0 after Ts.
- wrap and done are registered. They are high for exactly the one cycle following the qualifying edge.
- rst_n low mid-RUN: all state and outputs take their reset values immediately (asynchronous). Operation resumes only after a new start.

## Configuration
- STIM_GEN_BURST_EN defined:
  - burst_len port and done port exist.
  - A cycle counter runs in RUN.
  - After burst_len RUN edges (burst_len ≠ 0), the block returns to IDLE, pulses done, and holds out.
  - burst_len is captured at start.
  - A stop in the same edge as completion gives IDLE without a done pulse.
- Not defined: neither port exists, and RUN lasts until stop.

## Structure
- Package stim_gen_pkg holds:
  - state enum (IDLE, RUN)
  - default-period function (k+1)
  - the CH_SEL_W helper
- One sub-module, stim_chan: a single channel's counter, compare, and toggle flop with load/clear inputs. It is instantiated NUM_CH times by generate.
- Top level holds the FSM, period register file, and wrap/done logic.

## Test plan
- Reset defaults: after rst_n release, start with init_val = 4'b0111. Required: out toggles at edges +1/+2/+3/+4 for ch0..3. wrap first pulses after edge +12.
- Reprogram: in RUN, write ch2 period_val = 5. Required: out[2] next toggles 5 edges after the write, and other channels are unaffected.
- Freeze: write ch1 period_val = 0. Required: out[1] constant. wrap now qualifies on channels 0, 2, 3 only.
- Start/stop collision: in RUN, assert start and stop on the same edge. Required: IDLE, busy = 0, out held.
- Async reset mid-RUN: pull rst_n low between edges. Required: out = 0 and busy = 0 without a clock edge.
- Burst (STIM_GEN_BURST_EN): burst_len = 10, start. Required: busy for 10 edges, then done pulses for one cycle and out freezes.
